fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter, which drives the IM address input, and the IF/ID pipeline register, which captures the IM output word for the D stage.
- Selects the next PC from four sources: sequential, branch/jump target from D, exception handler vector, and EPC on eret.
- Detects fetch address errors (AdEL).

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_addr_check.sv | 15 +
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: fetch address map, exception codes and the nop word.
package cpu_defs;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: D-stage redirect controls, CP0 controls, IM port and IF/ID outputs.
interface fetch_unit_if;

  logic        en;
  logic        d_is_jb;
  logic        npc_sel;
  logic [31:0] npc_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_bd;
  logic [4:0]  d_exccode;
  logic        d_valid;

  // Pipeline / memory side: drives controls and the IM word, observes IF/ID.
  modport master (
    output en, d_is_jb, npc_sel, npc_target, exc_req, eret, epc, im_instr,
    input  pc, d_instr, d_pc, d_pc8, d_bd, d_exccode, d_valid
  );

  // Fetch unit side.
  modport slave (
    input  en, d_is_jb, npc_sel, npc_target, exc_req, eret, epc, im_instr,
    output pc, d_instr, d_pc, d_pc8, d_bd, d_exccode, d_valid
  );

endinterface

// File: rtl/fetch_unit_addr_check.sv
// Word-address range/alignment check; flags any address that cannot be fetched.
module fetch_addr_check
  import cpu_defs::*;
#(
  parameter logic [31:0] LO = IM_LO,
  parameter logic [31:0] HI = IM_HI
) (
  input  logic [31:0] addr,
  output logic        fault
);

  // Misaligned, below the window or above the last word (unsigned compares).
  assign fault = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: program counter, next-PC select, AdEL detection
// and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
  parameter logic [31:0] IM_LO      = cpu_defs::IM_LO,
  parameter logic [31:0] IM_HI      = cpu_defs::IM_HI
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  import cpu_defs::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_bd_q, d_bd_d;
  logic [4:0]  d_exccode_q, d_exccode_d;
  logic        d_valid_q, d_valid_d;
  logic        fetch_fault;
  logic        flush;

  fetch_addr_check #(
    .LO (IM_LO),
    .HI (IM_HI)
  ) u_addr_check (
    .addr  (pc_q),
    .fault (fetch_fault)
  );

  // Exceptions and eret redirect even while the hazard unit stalls.
  assign flush = bus.exc_req | bus.eret;

  // Next PC: exception vector, then EPC, then stall, then D redirect, then +4.
  always_comb begin
    pc_d = pc_q;
    if (bus.exc_req) begin
      pc_d = HANDLER_PC;
    end else if (bus.eret) begin
      pc_d = bus.epc;
    end else if (!bus.en) begin
      pc_d = pc_q;
    end else if (bus.npc_sel) begin
      pc_d = bus.npc_target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // IF/ID next value: flush to a bubble, hold on stall, otherwise capture the
  // fetched word. A taken branch does not flush: this fetch is its delay slot.
  always_comb begin
    d_instr_d   = d_instr_q;
    d_pc_d      = d_pc_q;
    d_bd_d      = d_bd_q;
    d_exccode_d = d_exccode_q;
    d_valid_d   = d_valid_q;
    if (flush) begin
      d_instr_d   = NOP;
      d_pc_d      = pc_q;
      d_bd_d      = 1'b0;
      d_exccode_d = EXC_NONE;
      d_valid_d   = 1'b0;
    end else if (bus.en) begin
      d_pc_d    = pc_q;
      d_bd_d    = bus.d_is_jb;
      d_valid_d = 1'b1;
      if (fetch_fault) begin
        d_instr_d   = NOP;
        d_exccode_d = EXC_ADEL;
      end else begin
        d_instr_d   = bus.im_instr;
        d_exccode_d = EXC_NONE;
      end
    end
  end

  // PC and IF/ID registers; reset takes effect immediately on assertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      d_instr_q   <= NOP;
      d_pc_q      <= RESET_PC;
      d_bd_q      <= 1'b0;
      d_exccode_q <= EXC_NONE;
      d_valid_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      d_instr_q   <= d_instr_d;
      d_pc_q      <= d_pc_d;
      d_bd_q      <= d_bd_d;
      d_exccode_q <= d_exccode_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.d_instr   = d_instr_q;
  assign bus.d_pc      = d_pc_q;
  assign bus.d_pc8     = d_pc_q + 32'd8;
  assign bus.d_bd      = d_bd_q;
  assign bus.d_exccode = d_exccode_q;
  assign bus.d_valid   = d_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what the PC and the D-stage slot should hold.
  logic [31:0] m_pc, m_instr, m_dpc;
  logic        m_bd, m_valid;
  logic [4:0]  m_exc;

  function automatic bit ref_fault(input logic [31:0] a);
    return ((a % 4) != 0) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'h0; m_dpc = 32'h0000_3000;
    m_bd = 1'b0; m_exc = 5'd0; m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance one clock, advance the model.
  task automatic cycle(input logic en, input logic jb, input logic sel,
                       input logic [31:0] tgt, input logic exc, input logic er,
                       input logic [31:0] epc, input logic [31:0] im);
    logic [31:0] n_pc, n_instr, n_dpc;
    logic        n_bd, n_valid;
    logic [4:0]  n_exc;
    bus.en = en; bus.d_is_jb = jb; bus.npc_sel = sel; bus.npc_target = tgt;
    bus.exc_req = exc; bus.eret = er; bus.epc = epc; bus.im_instr = im;
    n_pc = m_pc; n_instr = m_instr; n_dpc = m_dpc;
    n_bd = m_bd; n_valid = m_valid; n_exc = m_exc;
    if (exc || er) begin
      n_pc = exc ? 32'h0000_4180 : epc;
      n_instr = 32'h0; n_dpc = m_pc; n_bd = 1'b0; n_exc = 5'd0; n_valid = 1'b0;
    end else if (en) begin
      n_pc = sel ? tgt : m_pc + 32'd4;
      n_dpc = m_pc; n_bd = jb; n_valid = 1'b1;
      n_instr = ref_fault(m_pc) ? 32'h0 : im;
      n_exc = ref_fault(m_pc) ? 5'd4 : 5'd0;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_dpc = n_dpc;
    m_bd = n_bd; m_valid = n_valid; m_exc = n_exc;
  endtask

  task automatic seq(input logic [31:0] im);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, im);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b1; bus.d_is_jb = 1'b0; bus.npc_sel = 1'b0; bus.npc_target = 32'h0;
    bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = 32'h0; bus.im_instr = 32'h2408_0001;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (bus.pc !== 32'h0000_3000) begin failures++; $display("FAIL rst_pc actual=%h expected=%h", bus.pc, 32'h3000); end
    checks++; if (bus.d_pc !== 32'h0000_3000) begin failures++; $display("FAIL rst_d_pc actual=%h expected=%h", bus.d_pc, 32'h3000); end
    checks++; if (bus.d_instr !== 32'h0) begin failures++; $display("FAIL rst_d_instr actual=%h expected=0", bus.d_instr); end
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid actual=%b expected=0", bus.d_valid); end
    checks++; if (bus.d_bd !== 1'b0) begin failures++; $display("FAIL rst_d_bd actual=%b expected=0", bus.d_bd); end
    checks++; if (bus.d_exccode !== 5'd0) begin failures++; $display("FAIL rst_d_exccode actual=%0d expected=0", bus.d_exccode); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
    for (int i = 0; i < 3; i++) begin
      seq(32'h2408_0001);
      checks++; if (bus.pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc%0d actual=%h expected=%h", i, bus.pc, exp_pc[i]); end
      if (i == 0) begin
        checks++; if (bus.d_pc !== 32'h3000) begin failures++; $display("FAIL seq_d_pc actual=%h expected=3000", bus.d_pc); end
        checks++; if (bus.d_valid !== 1'b1) begin failures++; $display("FAIL seq_d_valid actual=%b expected=1", bus.d_valid); end
        checks++; if (bus.d_exccode !== 5'd0) begin failures++; $display("FAIL seq_d_exc actual=%0d expected=0", bus.d_exccode); end
        checks++; if (bus.d_instr !== 32'h2408_0001) begin failures++; $display("FAIL seq_d_instr actual=%h expected=24080001", bus.d_instr); end
        checks++; if (bus.d_pc8 !== 32'h3008) begin failures++; $display("FAIL seq_d_pc8 actual=%h expected=3008", bus.d_pc8); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_pc, s_instr, s_dpc;
    logic        s_bd, s_valid;
    logic [4:0]  s_exc;
    s_pc = m_pc; s_instr = m_instr; s_dpc = m_dpc; s_bd = m_bd; s_valid = m_valid; s_exc = m_exc;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0, 32'h1111_0000 + i);
      checks++; if (bus.pc !== s_pc) begin failures++; $display("FAIL stall_pc actual=%h expected=%h", bus.pc, s_pc); end
      checks++; if (bus.d_instr !== s_instr || bus.d_pc !== s_dpc || bus.d_bd !== s_bd ||
                    bus.d_valid !== s_valid || bus.d_exccode !== s_exc) begin
        failures++;
        $display("FAIL stall_ifid actual=%h/%h/%b/%b/%0d expected=%h/%h/%b/%b/%0d", bus.d_instr, bus.d_pc,
                 bus.d_bd, bus.d_valid, bus.d_exccode, s_instr, s_dpc, s_bd, s_valid, s_exc);
      end
    end
    seq(32'h2408_0002);
    checks++; if (bus.pc !== s_pc + 32'd4) begin failures++; $display("FAIL stall_resume_pc actual=%h expected=%h", bus.pc, s_pc + 32'd4); end
    checks++; if (bus.d_pc !== s_pc) begin failures++; $display("FAIL stall_resume_d_pc actual=%h expected=%h", bus.d_pc, s_pc); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 16 && m_pc != 32'h3010; i++) seq(32'h2408_0003);
    cycle(1'b1, 1'b1, 1'b1, 32'h3040, 1'b0, 1'b0, 32'h0, 32'h2408_0004);
    checks++; if (bus.pc !== 32'h3040) begin failures++; $display("FAIL br_pc actual=%h expected=3040", bus.pc); end
    checks++; if (bus.d_pc !== 32'h3010) begin failures++; $display("FAIL br_d_pc actual=%h expected=3010", bus.d_pc); end
    checks++; if (bus.d_bd !== 1'b1) begin failures++; $display("FAIL br_d_bd actual=%b expected=1", bus.d_bd); end
    checks++; if (bus.d_valid !== 1'b1) begin failures++; $display("FAIL br_d_valid actual=%b expected=1", bus.d_valid); end
    seq(32'h2408_0005);
    checks++; if (bus.d_pc !== 32'h3040) begin failures++; $display("FAIL br_tgt_d_pc actual=%h expected=3040", bus.d_pc); end
    checks++; if (bus.d_bd !== 1'b0) begin failures++; $display("FAIL br_tgt_d_bd actual=%b expected=0", bus.d_bd); end
    checks++; if (bus.pc !== 32'h3044) begin failures++; $display("FAIL br_tgt_pc actual=%h expected=3044", bus.pc); end
  endtask

  task automatic test_exception();
    cycle(1'b0, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1, 32'h3024, 32'h2408_0006);
    checks++; if (bus.pc !== 32'h4180) begin failures++; $display("FAIL exc_pc actual=%h expected=4180", bus.pc); end
    checks++; if (bus.d_instr !== 32'h0) begin failures++; $display("FAIL exc_d_instr actual=%h expected=0", bus.d_instr); end
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL exc_d_valid actual=%b expected=0", bus.d_valid); end
    checks++; if (bus.d_bd !== 1'b0) begin failures++; $display("FAIL exc_d_bd actual=%b expected=0", bus.d_bd); end
    checks++; if (bus.d_pc !== 32'h3044) begin failures++; $display("FAIL exc_d_pc actual=%h expected=3044", bus.d_pc); end
  endtask

  task automatic test_eret();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3024, 32'h2408_0007);
    checks++; if (bus.pc !== 32'h3024) begin failures++; $display("FAIL eret_pc actual=%h expected=3024", bus.pc); end
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL eret_d_valid actual=%b expected=0", bus.d_valid); end
    checks++; if (bus.d_instr !== 32'h0) begin failures++; $display("FAIL eret_d_instr actual=%h expected=0", bus.d_instr); end
    checks++; if (bus.d_pc !== 32'h4180) begin failures++; $display("FAIL eret_d_pc actual=%h expected=4180", bus.d_pc); end
    seq(32'h2408_0008);
    checks++; if (bus.d_pc !== 32'h3024) begin failures++; $display("FAIL eret_next_d_pc actual=%h expected=3024", bus.d_pc); end
    checks++; if (bus.d_valid !== 1'b1) begin failures++; $display("FAIL eret_next_d_valid actual=%b expected=1", bus.d_valid); end
    checks++; if (bus.d_instr !== 32'h2408_0008) begin failures++; $display("FAIL eret_next_d_instr actual=%h expected=24080008", bus.d_instr); end
  endtask

  task automatic test_adel();
    logic [31:0] im;
    im = 32'hDEAD_BEEF;
    cycle(1'b1, 1'b1, 1'b1, 32'h3002, 1'b0, 1'b0, 32'h0, im);
    seq(im);
    checks++; if (bus.d_pc !== 32'h3002 || bus.d_exccode !== 5'd4 || bus.d_instr !== 32'h0) begin
      failures++; $display("FAIL adel_misalign actual=%h/%0d/%h expected=3002/4/0", bus.d_pc, bus.d_exccode, bus.d_instr); end
    cycle(1'b1, 1'b1, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0, im);
    seq(im);
    checks++; if (bus.d_pc !== 32'h7000 || bus.d_exccode !== 5'd4 || bus.d_instr !== 32'h0) begin
      failures++; $display("FAIL adel_high actual=%h/%0d/%h expected=7000/4/0", bus.d_pc, bus.d_exccode, bus.d_instr); end
    checks++; if (bus.d_valid !== 1'b1) begin failures++; $display("FAIL adel_valid actual=%b expected=1", bus.d_valid); end
    cycle(1'b1, 1'b0, 1'b1, 32'h6FFC, 1'b0, 1'b0, 32'h0, im);
    seq(im);
    checks++; if (bus.d_pc !== 32'h6FFC || bus.d_exccode !== 5'd0 || bus.d_instr !== im) begin
      failures++; $display("FAIL adel_top_word actual=%h/%0d/%h expected=6ffc/0/%h", bus.d_pc, bus.d_exccode, bus.d_instr, im); end
    cycle(1'b1, 1'b0, 1'b1, 32'h2FFC, 1'b0, 1'b0, 32'h0, im);
    seq(im);
    checks++; if (bus.d_pc !== 32'h2FFC || bus.d_exccode !== 5'd4) begin
      failures++; $display("FAIL adel_low actual=%h/%0d expected=2ffc/4", bus.d_pc, bus.d_exccode); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, im);
    seq(im);
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL pc_wrap actual=%h expected=0", bus.pc); end
    checks++; if (bus.d_pc8 !== 32'h4) begin failures++; $display("FAIL pc8_wrap actual=%h expected=4", bus.d_pc8); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    seq(32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h3000) begin failures++; $display("FAIL async_rst_pc actual=%h expected=3000", bus.pc); end
    checks++; if (bus.d_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid actual=%b expected=0", bus.d_valid); end
    checks++; if (bus.d_pc !== 32'h3000) begin failures++; $display("FAIL async_rst_d_pc actual=%h expected=3000", bus.d_pc); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    seq(32'h2408_0009);
    checks++; if (bus.pc !== 32'h3004 || bus.d_pc !== 32'h3000 || bus.d_valid !== 1'b1) begin
      failures++; $display("FAIL async_rst_first_fetch actual=%h/%h/%b expected=3004/3000/1", bus.pc, bus.d_pc, bus.d_valid); end
  endtask

  task automatic test_random();
    logic        en, jb, sel, exc, er;
    logic [31:0] tgt, epc;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      jb  = $urandom_range(0, 1) == 1;
      sel = ($urandom_range(0, 3) == 0);
      exc = ($urandom_range(0, 19) == 0);
      er  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 4) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 4100) << 2);
      epc = 32'h3000 + ($urandom_range(0, 4095) << 2);
      cycle(en, jb, sel, tgt, exc, er, epc, $urandom);
      checks++;
      if (bus.pc !== m_pc || bus.d_instr !== m_instr || bus.d_pc !== m_dpc || bus.d_pc8 !== m_dpc + 32'd8 ||
          bus.d_bd !== m_bd || bus.d_valid !== m_valid || bus.d_exccode !== m_exc) begin
        failures++;
        $display("FAIL rand_%0d actual=%h/%h/%h/%b/%b/%0d expected=%h/%h/%h/%b/%b/%0d", i, bus.pc, bus.d_instr,
                 bus.d_pc, bus.d_bd, bus.d_valid, bus.d_exccode, m_pc, m_instr, m_dpc, m_bd, m_valid, m_exc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_exception();
    test_eret();
    test_adel();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
